// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receive-chain definitions: default FFT geometry, CP encodings,
// framer state encoding and complex sample field positions.
package ofdm_rx_pkg;

  localparam int unsigned NFFT_DEF = 2048;
  localparam int unsigned LOGN_DEF = 11;

  localparam logic [1:0] CP_1_4  = 2'b00;
  localparam logic [1:0] CP_1_8  = 2'b01;
  localparam logic [1:0] CP_1_16 = 2'b10;
  localparam logic [1:0] CP_1_32 = 2'b11;

  localparam int unsigned RE_LO = 0;
  localparam int unsigned RE_HI = 15;
  localparam int unsigned IM_LO = 16;
  localparam int unsigned IM_HI = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    PASS  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int unsigned cp_len_of(input int unsigned nfft, input logic [1:0] sel);
    int unsigned len;
    case (sel)
      CP_1_4:  len = nfft >> 2;
      CP_1_8:  len = nfft >> 3;
      CP_1_16: len = nfft >> 4;
      default: len = nfft >> 5;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ws_out_reg.sv
// One-entry Wishbone-style output register; o_ready is the upstream ACK
// back-pressure term (cycle active and register empty or draining).
module ws_out_reg #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cyc,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic         o_stb,
  output logic [W-1:0] o_data,
  output logic         o_ready
);

  logic         r_stb;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stb  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_stb  <= 1'b1;
      r_data <= i_data;
    end else if (i_ack) begin
      r_stb  <= 1'b0;
    end
  end

  assign o_stb   = r_stb;
  assign o_data  = r_data;
  assign o_ready = i_cyc & (~r_stb | i_ack);

endmodule

// File: rtl/cp_strip_framer.sv
// Cyclic-prefix stripper: drops the CP of each OFDM symbol, forwards NFFT
// useful samples per symbol, counts symbols and flags truncated frames.
module cp_strip_framer
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned NFFT = NFFT_DEF,
  parameter int unsigned LOGN = LOGN_DEF,
  parameter int unsigned SYMW = 8
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [31:0]     DAT_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  output logic            ACK_O,
  input  logic [1:0]      cp_sel,
  output logic [31:0]     DAT_O,
  output logic            WE_O,
  output logic            STB_O,
  output logic            CYC_O,
  input  logic            ACK_I,
  output logic [SYMW-1:0] sym_idx,
  output logic            sym_start,
  output logic            frm_err
);

  state_t          r_state;
  logic [LOGN-1:0] r_cnt;
  logic [LOGN-1:0] r_cp_len;
  logic [SYMW-1:0] r_sym_idx;
  logic            r_cyc_d;
  logic            r_cyc_o;
  logic            r_frm_err;

  logic            w_ready;
  logic            w_xfer;
  logic            w_load;
  logic            w_rise;
  logic            w_last_o;
  logic            w_unused;
  logic [LOGN-1:0] w_cp_len_new;
  logic [33:0]     w_pay_in;
  logic [33:0]     w_pay_out;

  assign w_unused     = WE_I;
  assign w_rise       = CYC_I & ~r_cyc_d;
  assign w_cp_len_new = LOGN'(cp_len_of(NFFT, cp_sel));
  // FLUSH refuses input even if CYC_I has already risen again for the next frame.
  assign ACK_O        = w_ready & (r_state != FLUSH);
  assign w_xfer       = CYC_I & STB_I & ACK_O;
  assign w_load       = w_xfer & (r_state == PASS);
  assign w_pay_in     = {(r_cnt == LOGN'(NFFT - 1)), (r_cnt == '0), DAT_I};

  ws_out_reg #(
    .W(34)
  ) u_out (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .i_cyc  (CYC_I),
    .i_load (w_load),
    .i_data (w_pay_in),
    .i_ack  (ACK_I),
    .o_stb  (STB_O),
    .o_data (w_pay_out),
    .o_ready(w_ready)
  );

  assign DAT_O     = w_pay_out[31:0];
  assign sym_start = w_pay_out[32];
  assign w_last_o  = w_pay_out[33];
  assign WE_O      = STB_O;
  assign CYC_O     = r_cyc_o;
  assign sym_idx   = r_sym_idx;
  assign frm_err   = r_frm_err;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cp_len  <= '0;
      r_sym_idx <= '0;
      r_cyc_d   <= 1'b0;
      r_cyc_o   <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_cyc_d   <= CYC_I;
      r_frm_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_cp_len  <= w_cp_len_new;
            r_sym_idx <= '0;
            // The rising-edge sample is already the first CP sample.
            r_cnt     <= w_xfer ? LOGN'(1) : '0;
            r_state   <= SKIP;
          end
        end
        SKIP: begin
          if (!CYC_I) begin
            r_frm_err <= (r_cnt != '0);
            r_cnt     <= '0;
            r_state   <= FLUSH;
          end else if (w_xfer) begin
            if (r_cnt == r_cp_len - 1'b1) begin
              r_cnt   <= '0;
              r_state <= PASS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        PASS: begin
          if (!CYC_I) begin
            r_frm_err <= 1'b1;
            r_cnt     <= '0;
            r_state   <= FLUSH;
          end else if (w_xfer) begin
            r_cyc_o <= 1'b1;
            if (r_cnt == LOGN'(NFFT - 1)) begin
              r_cnt   <= '0;
              r_state <= SKIP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (!STB_O) begin
            r_cyc_o <= 1'b0;
            // A frame raised during the drain starts now with a fresh CP latch.
            if (CYC_I) begin
              r_cp_len  <= w_cp_len_new;
              r_sym_idx <= '0;
              r_cnt     <= '0;
              r_state   <= SKIP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
      endcase
      if (STB_O && ACK_I && w_last_o) begin
        r_sym_idx <= r_sym_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp_strip_framer.sv
// Randomised self-checking bench for cp_strip_framer with NFFT=64; a frame-level
// arithmetic model predicts every forwarded sample, plus literal anchor checks.
module tb_cp_strip_framer;

  localparam int unsigned N = 64;

  logic        CLK_I, RST_I, CYC_I, STB_I, WE_I, ACK_I;
  logic [31:0] DAT_I, DAT_O;
  logic [1:0]  cp_sel;
  logic        ACK_O, WE_O, STB_O, CYC_O, sym_start, frm_err;
  logic [7:0]  sym_idx;

  cp_strip_framer #(
    .NFFT(64),
    .LOGN(6),
    .SYMW(8)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .DAT_I    (DAT_I),
    .CYC_I    (CYC_I),
    .STB_I    (STB_I),
    .WE_I     (WE_I),
    .ACK_O    (ACK_O),
    .cp_sel   (cp_sel),
    .DAT_O    (DAT_O),
    .WE_O     (WE_O),
    .STB_O    (STB_O),
    .CYC_O    (CYC_O),
    .ACK_I    (ACK_I),
    .sym_idx  (sym_idx),
    .sym_start(sym_start),
    .frm_err  (frm_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        st;
    logic [7:0]  sym;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          got_starts;
  int          n_checks;
  int          n_errors;
  int          n_ferr;
  int unsigned m_cp;
  int unsigned m_idx;
  int          ack_mode;
  logic        hold_prev;
  logic [31:0] prev_dat;
  logic [7:0]  prev_sym;
  logic        prev_st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // ACK_I pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  always begin
    @(posedge CLK_I);
    #1;
    case (ack_mode)
      0: ACK_I = 1'b1;
      1: ACK_I = ((($time / 10) % 4) == 0) || ((($time / 10) % 4) == 3);
      default: ACK_I = ($urandom_range(99) < 60);
    endcase
  end

  // Monitor and model: an accepted sample at frame position i lands at offset
  // i mod (CP+N) within its symbol; offsets >= CP are forwarded in order.
  always @(negedge CLK_I) begin
    if (RST_I) begin
      hold_prev = 1'b0;
    end else begin
      chk("ack_eq", ACK_O, CYC_I & (~STB_O | ACK_I));
      chk("we_eq", WE_O, STB_O);
      if (STB_O) chk("cyc_o_with_stb", CYC_O, 1);
      if (hold_prev) begin
        chk("hold_stb", STB_O, 1);
        chk("hold_dat", DAT_O, prev_dat);
        chk("hold_sym", sym_idx, prev_sym);
        chk("hold_start", sym_start, prev_st);
      end
      if (STB_O && ACK_I) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_out: got %0h expected none", DAT_O);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_dat", DAT_O, e.d);
          chk("out_start", sym_start, e.st);
          chk("out_sym", sym_idx, e.sym);
        end
        got_q.push_back(DAT_O);
        if (sym_start) got_starts++;
      end
      if (frm_err) n_ferr++;
      if (CYC_I && STB_I && ACK_O) begin
        int unsigned p;
        p = m_idx % (m_cp + N);
        if (p >= m_cp) begin
          exp_t e;
          e.d   = DAT_I;
          e.st  = (p == m_cp);
          e.sym = 8'((m_idx / (m_cp + N)) % 256);
          exp_q.push_back(e);
        end
        m_idx++;
      end
      hold_prev = STB_O & ~ACK_I;
      prev_dat  = DAT_O;
      prev_sym  = sym_idx;
      prev_st   = sym_start;
    end
  end

  task automatic send_sample(input logic [31:0] d, input int unsigned pct, output bit ok);
    int unsigned w;
    bit done;
    done = 1'b0;
    w    = 0;
    DAT_I = d;
    while (!done && w < 200) begin
      STB_I = ($urandom_range(99) < pct);
      @(negedge CLK_I);
      done = STB_I & ACK_O;
      @(posedge CLK_I);
      #1;
      w++;
    end
    STB_I = 1'b0;
    ok = done;
    if (!done) fail("accept_timeout");
  endtask

  task automatic start_frame(input logic [1:0] sel);
    m_cp  = N >> (2 + sel);
    m_idx = 0;
    n_ferr = 0;
    got_q.delete();
    got_starts = 0;
    cp_sel = sel;
    CYC_I  = 1'b1;
  endtask

  task automatic end_frame(input int unsigned n);
    int unsigned w;
    bit exp_err;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    w = 0;
    while ((exp_q.size() != 0 || CYC_O || STB_O) && w < 400) begin
      @(negedge CLK_I);
      w++;
    end
    if (w >= 400) fail("drain_timeout");
    repeat (4) @(posedge CLK_I);
    #1;
    exp_err = (m_idx % (m_cp + N)) != 0;
    chk("frm_err_count", n_ferr, exp_err);
    chk("accept_count", m_idx, n);
    chk("idle_cyc_o", CYC_O, 0);
  endtask

  task automatic send_frame(input logic [1:0] sel, input int unsigned n, input bit ramp,
                            input int unsigned pct, input int mid_at, input logic [1:0] mid_sel);
    bit ok;
    start_frame(sel);
    for (int unsigned i = 0; i < n; i++) begin
      if (int'(i) == mid_at) cp_sel = mid_sel;
      send_sample(ramp ? i : $urandom, pct, ok);
      if (!ok) break;
    end
    end_frame(n);
  endtask

  initial begin
    bit ok;
    n_checks = 0; n_errors = 0; n_ferr = 0; got_starts = 0;
    m_cp = 16; m_idx = 0; hold_prev = 1'b0;
    ack_mode = 0; ACK_I = 1'b1;
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b1; DAT_I = '0; cp_sel = 2'b00;
    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_stb", STB_O, 0);
    chk("rst_cyc", CYC_O, 0);
    chk("rst_sym", sym_idx, 0);
    chk("rst_err", frm_err, 0);
    chk("rst_dat", DAT_O, 0);
    chk("rst_start", sym_start, 0);
    RST_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;

    // Two full symbols, CP 1/4, no stalls.
    send_frame(2'b00, 160, 1'b1, 100, -1, 2'b00);
    chk("t1_count", got_q.size(), 128);
    if (got_q.size() == 128) begin
      chk("t1_first", got_q[0], 16);
      chk("t1_end_sym0", got_q[63], 79);
      chk("t1_start_sym1", got_q[64], 96);
      chk("t1_last", got_q[127], 159);
    end
    chk("t1_starts", got_starts, 2);
    chk("t1_ferr", n_ferr, 0);

    // CP 1/32 ramp of 66: exactly one symbol, counter back in SKIP at 0.
    send_frame(2'b11, 66, 1'b1, 100, -1, 2'b00);
    chk("t2_count", got_q.size(), 64);
    if (got_q.size() == 64) begin
      chk("t2_first", got_q[0], 2);
      chk("t2_last", got_q[63], 65);
    end
    chk("t2_ferr", n_ferr, 0);

    // Back-pressure 1,0,0,1 with a gappy input, two symbols.
    ack_mode = 1;
    send_frame(2'b00, 160, 1'b0, 70, -1, 2'b00);
    chk("t3_count", got_q.size(), 128);
    ack_mode = 0;

    // Frame truncated 30 samples into the symbol.
    send_frame(2'b00, 46, 1'b1, 100, -1, 2'b00);
    chk("t4_count", got_q.size(), 30);
    if (got_q.size() == 30) begin
      chk("t4_first", got_q[0], 16);
      chk("t4_last", got_q[29], 45);
    end
    chk("t4_ferr", n_ferr, 1);

    // cp_sel changes mid-frame; only the next frame picks it up.
    send_frame(2'b00, 80, 1'b1, 100, 5, 2'b10);
    chk("t5a_count", got_q.size(), 64);
    if (got_q.size() != 0) chk("t5a_first", got_q[0], 16);
    send_frame(2'b10, 68, 1'b1, 100, -1, 2'b10);
    chk("t5b_count", got_q.size(), 64);
    if (got_q.size() != 0) chk("t5b_first", got_q[0], 4);

    // Reset in PASS with an occupied output register.
    start_frame(2'b00);
    for (int unsigned i = 0; i < 26; i++) begin
      send_sample(i, 100, ok);
      if (!ok) break;
    end
    chk("t6_pre_stb", STB_O, 1);
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0;
    @(posedge CLK_I);
    #1;
    exp_q.delete();
    m_idx = 0;
    chk("t6_stb", STB_O, 0);
    chk("t6_cyc", CYC_O, 0);
    chk("t6_sym", sym_idx, 0);
    chk("t6_err", frm_err, 0);
    RST_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    send_frame(2'b01, 72, 1'b1, 100, -1, 2'b01);
    chk("t6_after_count", got_q.size(), 64);
    if (got_q.size() != 0) chk("t6_after_first", got_q[0], 8);
    chk("t6_after_ferr", n_ferr, 0);

    // Random frames: random CP, length, input gaps and back-pressure.
    ack_mode = 2;
    for (int k = 0; k < 8; k++) begin
      send_frame(2'($urandom_range(3)), $urandom_range(1, 300), 1'b0,
                 $urandom_range(30, 100), -1, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cp_strip_framer.md
Name: cp_strip_framer

Overview:
- Sits directly downstream of the receiver synchronisation stage.
- Consumes the time-synchronised, CFO-compensated complex sample stream over the Wishbone-style master interface of that stage.
- Discards the cyclic prefix of every OFDM symbol and forwards exactly NFFT useful samples per symbol to the FFT stage over an identical Wishbone-style stream.
- Counts symbols, and flags a frame that ends mid-symbol.

Parameters:
- NFFT, 2048, FFT size / useful samples per symbol; power of two, 64..2048.
- LOGN, 11, log2(NFFT); width of the sample counter.
- SYMW, 8, width of the symbol counter.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset.
- DAT_I  in  32  input sample; [31:16] imag, [15:0] real, format 2.14.
- CYC_I  in  1  input frame active; high for the whole frame.
- STB_I  in  1  input sample valid.
- WE_I  in  1  write strobe from upstream; ignored, upstream always writes.
- ACK_O  out  1  input sample accepted this cycle.
- cp_sel  in  2  CP length: 00=NFFT/4, 01=NFFT/8, 10=NFFT/16, 11=NFFT/32.
- DAT_O  out  32  useful sample to FFT; same format as DAT_I.
- WE_O  out  1  write strobe; equals STB_O.
- STB_O  out  1  output sample valid.
- CYC_O  out  1  output frame active.
- ACK_I  in  1  FFT stage accepts the output sample.
- sym_idx  out  SYMW  index of the symbol currently being output; wraps modulo 2^SYMW.
- sym_start  out  1  high with the first useful sample (k=0) of each symbol while STB_O is high.
- frm_err  out  1  one-cycle pulse when a frame ends inside a symbol.

Behaviour:
- Clock and reset: one clock, CLK_I; reset is synchronous and active-high (RST_I).
- Reset values: ACK_O is combinational. All registered outputs reset to 0: DAT_O, STB_O, WE_O, CYC_O, sym_idx, sym_start, frm_err. State resets to IDLE and all counters to 0.
- Input transfer: occurs when CYC_I & STB_I & ACK_O.
- ACK_O: combinational, = CYC_I & (~STB_O | ACK_I). No combinational path from DAT_I to any output.
- Output register: a single output register.
  - Output transfer occurs when STB_O & ACK_I.
  - DAT_O, sym_idx and sym_start hold stable while STB_O & ~ACK_I.
- Latency: a passed sample appears on DAT_O/STB_O one cycle after its input transfer.
- Frame start (CYC_I rising, i.e. previous registered CYC_I=0 and CYC_I=1):
  - Latch cp_sel into cp_len_r, computed as NFFT>>(2+cp_sel).
  - Clear the sample counter cnt, sym_idx and the symbol phase.
  - Enter SKIP.
  - cp_sel changes mid-frame are ignored.
- States:
  - IDLE: ACK_O follows its equation, but there is no frame yet; on CYC_I rise go to SKIP.
  - SKIP:
    - Every input transfer is acked and discarded; cnt++.
    - When cnt reaches cp_len_r-1 on a transfer: cnt <= 0, go to PASS.
  - PASS:
    - Every input transfer is loaded into the output register; cnt++.
    - sym_start is set when cnt==0.
    - When cnt==NFFT-1 on a transfer: cnt <= 0, go to SKIP.
    - sym_idx increments once the last sample of the symbol has left the output register.
  - FLUSH: entered when CYC_I falls. Accept nothing, wait for the output register to drain (STB_O=0), then deassert CYC_O and go to IDLE.
- CYC_O:
  - Set with the first output sample of a frame.
  - Cleared in FLUSH once drained.
  - Never high in IDLE.
- frm_err: pulses for one cycle on CYC_I fall if state ≠ SKIP or cnt ≠ 0 (partial CP or partial symbol).
  - Samples already forwarded are not retracted.
  - A partial symbol is not padded.
- Simultaneous events:
  - A CYC_I fall in the same cycle as STB_I: that sample is not accepted (ACK_O=0 because CYC_I=0).
  - A CYC_I rise while in FLUSH: finish the drain first, then start the frame from SKIP with a fresh cp_sel latch.
- Reset mid-operation: immediately aborts; no frm_err pulse.
- Counter: cnt is LOGN bits and never exceeds NFFT-1.

Decomposition:
- Shared package (ofdm_rx_pkg):
  - NFFT and LOGN defaults.
  - The cp_sel encodings and the localparams CP_1_4, CP_1_8, CP_1_16, CP_1_32.
  - The state encoding (IDLE, SKIP, PASS, FLUSH).
  - Sample field slices (RE = [15:0], IM = [31:16]).
- Natural sub-module: ws_out_reg, a one-entry Wishbone-style output register with the ACK_O back-pressure equation. It is reused by later RX stages.

Test Plan:
- NFFT=64, cp_sel=00, one frame of 2×(16+64) samples, STB_I always high, ACK_I always high -> exactly samples 16..79 and 96..159 appear on DAT_O. sym_start is high on samples 16 and 96. sym_idx is 0 then 1. frm_err stays 0.
- NFFT=64, cp_sel=11, input ramp 0..65 -> outputs 2..65; CP of 2 dropped; cnt wraps back into SKIP.
- Back-pressure: ACK_I toggles 1,0,0,1 repeatedly, with a full frame -> no sample is lost or duplicated; DAT_O is stable while ACK_I=0; ACK_O=0 whenever STB_O=1 & ACK_I=0.
- CYC_I drops after 16+30 samples (cp_sel=00) -> 30 samples are output; frm_err pulses once; CYC_O falls after the last sample drains; the block returns to IDLE.
- cp_sel changed from 00 to 10 mid-frame -> the current frame still drops 16; the next frame (new CYC_I rise) drops 4.
- RST_I asserted mid-PASS with STB_O=1 -> the next cycle has STB_O=0, CYC_O=0, sym_idx=0 and frm_err=0; a following frame is processed normally.
